cmd_frame_parser: RTL and testbench
===================================

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of the received stream.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum idle gap between bytes of one frame.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port CLK  input  1  the single clock.
REQ-006 SHALL have port RST  input  1  synchronous active-high reset.
REQ-007 SHALL have port rx_data  input  DATA_WIDTH  byte delivered by the upstream data synchronizer (its sync_bus).
REQ-008 SHALL have port rx_valid  input  1  single-cycle strobe qualifying rx_data (the synchronizer's enable_pulse).
REQ-009 SHALL have port cmd_ready  input  1  downstream controller accepts the held command.
REQ-010 SHALL have port cmd_valid  output  1  decoded command is held on the cmd_* outputs.
REQ-011 SHALL have port cmd_type  output  2  00 REG_WR, 01 REG_RD, 10 ALU_OP, 11 ALU_NOP.
REQ-012 SHALL have port cmd_addr  output  ADDR_WIDTH  register address (low ADDR_WIDTH bits of the address byte).
REQ-013 SHALL have port cmd_data  output  DATA_WIDTH  write data (REG_WR) or operand A (ALU_OP).
REQ-014 SHALL have port cmd_opb  output  DATA_WIDTH  operand B (ALU_OP).
REQ-015 SHALL have port cmd_fun  output  4  ALU function (low 4 bits of the function byte).
REQ-016 SHALL have port frame_err  output  1  one-cycle pulse on bad opcode or frame timeout.
REQ-017 SHALL have port overrun  output  1  one-cycle pulse when a byte is dropped while a command is held.

Function
REQ-018 SHALL recognise frames: 0xAA addr data (REG_WR); 0xBB addr (REG_RD); 0xCC opA opB fun (ALU_OP); 0xDD fun (ALU_NOP).
REQ-019 SHALL implement states IDLE, ADDR, WDATA, OPA, OPB, FUN, HOLD; bytes advance state only on cycles with rx_valid=1.
REQ-020 SHALL transition IDLE->ADDR on 0xAA/0xBB, IDLE->OPA on 0xCC, IDLE->FUN on 0xDD; ADDR->WDATA (REG_WR) or ADDR->HOLD (REG_RD); WDATA->HOLD; OPA->OPB->FUN->HOLD.
REQ-021 SHALL, on any other byte in IDLE, stay in IDLE and pulse frame_err the following cycle.
REQ-022 SHALL assert cmd_valid in the cycle after the rx_valid of the final frame byte, holding all cmd_* stable until cmd_valid&cmd_ready.
REQ-023 SHALL leave HOLD for IDLE on cmd_ready=1; cmd_valid SHALL NOT depend combinationally on cmd_ready.
REQ-024 SHALL, on rx_valid in HOLD with cmd_ready=0, drop the byte and pulse overrun the next cycle.
REQ-025 SHALL, on rx_valid in HOLD with cmd_ready=1 in the same cycle, retire the command and decode the byte as an IDLE opcode byte.
REQ-026 SHALL run a frame timer in ADDR, WDATA, OPA, OPB, FUN, cleared on every accepted byte and held at 0 in IDLE and HOLD.
REQ-027 SHALL, when the timer reaches TIMEOUT_CYCLES-1 with no rx_valid, return to IDLE, discard partial fields and pulse frame_err.
REQ-028 SHALL give rx_valid priority over timeout when both occur in the same cycle.
REQ-029 SHALL leave cmd_addr, cmd_data, cmd_opb, cmd_fun unchanged for fields the frame type does not use.

Reset
REQ-030 SHALL on RST=1 at a CLK edge enter IDLE and clear cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_opb, cmd_fun, frame_err, overrun and the timer to 0.
REQ-031 SHALL abandon a partial or held frame on reset mid-operation without pulsing frame_err or overrun.
REQ-032 SHALL ignore rx_valid in the reset cycle.

Structure
REQ-033 SHALL take opcodes 0xAA/0xBB/0xCC/0xDD, cmd_type encodings and state encodings from a shared package cmd_defs_pkg.
REQ-034 SHALL implement the timeout counter as sub-module frame_timer (inputs clear, run; output expired).
REQ-035 SHALL register all outputs.

Verification
REQ-036 SHALL check AA 05 3C, cmd_ready=1 -> cmd_valid 1 cycle after 3C, type 00, addr 5, data 0x3C.
REQ-037 SHALL check CC 12 34 08 with cmd_ready=0 for 10 cycles, then 1 -> type 10, data 0x12, opb 0x34, fun 8, held stable throughout, one-cycle valid handshake.
REQ-038 SHALL check byte 0x7E in IDLE -> frame_err pulse, state IDLE, no cmd_valid.
REQ-039 SHALL check BB then no byte for TIMEOUT_CYCLES cycles -> frame_err pulse, then DD 03 -> type 11, fun 3.
REQ-040 SHALL check DD 01 held with cmd_ready=0, byte 0xAA arrives -> overrun pulse; repeat with cmd_ready=1 on the same cycle -> no overrun, next frame starts.
REQ-041 SHALL check RST=1 after CC 12 -> all outputs 0, a following AA 02 55 decodes correctly.

Source files
------------

// File: rtl/cmd_defs_pkg.sv
// Shared definitions for the command frame parser: opcode bytes, command
// type encodings and parser state encodings.
package cmd_defs_pkg;

  localparam logic [7:0] OP_REG_WR  = 8'hAA;
  localparam logic [7:0] OP_REG_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_REG_WR  = 2'b00,
    CMD_REG_RD  = 2'b01,
    CMD_ALU_OP  = 2'b10,
    CMD_ALU_NOP = 2'b11
  } cmd_type_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_OPA   = 3'd3,
    S_OPB   = 3'd4,
    S_FUN   = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  // States in which a frame is partially received and the idle gap is timed.
  function automatic logic is_timed(state_t s);
    return (s == S_ADDR) || (s == S_WDATA) || (s == S_OPA) ||
           (s == S_OPB)  || (s == S_FUN);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-gap counter for a frame in progress; expired flags the last allowed
// cycle so the parser can abandon the frame on that same edge.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/cmd_frame_parser.sv
// Parses opcode-led byte frames into register/ALU commands held under a
// valid/ready handshake, with bad-opcode, timeout and overrun reporting.
module cmd_frame_parser
  import cmd_defs_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_valid,
  output logic [1:0]            cmd_type,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic [DATA_WIDTH-1:0] cmd_opb,
  output logic [3:0]            cmd_fun,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [2:0]            fsm_state
);

  // Handshake: cmd_valid is registered and rises only after the final frame
  // byte; the cmd_* fields stay frozen until a cycle with cmd_valid and
  // cmd_ready both high, which retires the command on that edge.

  state_t                state;
  cmd_type_t             pend_type;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] opa_q;
  logic [DATA_WIDTH-1:0] opb_q;
  logic                  timed;
  logic                  expired;
  logic                  opcode_slot;

  assign timed     = is_timed(state);
  assign fsm_state = state;

  // A byte is read as an opcode in IDLE, or in HOLD when the command retires
  // on the same edge so back-to-back frames lose no cycle.
  assign opcode_slot = rx_valid &&
                       ((state == S_IDLE) || ((state == S_HOLD) && cmd_ready));

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (rx_valid),
    .run    (timed),
    .expired(expired)
  );

  always_ff @(posedge CLK) begin
    frame_err <= 1'b0;
    overrun   <= 1'b0;
    if (RST) begin
      state     <= S_IDLE;
      pend_type <= CMD_REG_WR;
      addr_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cmd_valid <= 1'b0;
      cmd_type  <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_opb   <= '0;
      cmd_fun   <= '0;
    end else begin
      if ((state == S_HOLD) && cmd_ready) begin
        cmd_valid <= 1'b0;
        state     <= S_IDLE;
      end
      if (opcode_slot) begin
        if (rx_data == DATA_WIDTH'(OP_REG_WR)) begin
          pend_type <= CMD_REG_WR;
          state     <= S_ADDR;
        end else if (rx_data == DATA_WIDTH'(OP_REG_RD)) begin
          pend_type <= CMD_REG_RD;
          state     <= S_ADDR;
        end else if (rx_data == DATA_WIDTH'(OP_ALU_OP)) begin
          pend_type <= CMD_ALU_OP;
          state     <= S_OPA;
        end else if (rx_data == DATA_WIDTH'(OP_ALU_NOP)) begin
          pend_type <= CMD_ALU_NOP;
          state     <= S_FUN;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (timed && !rx_valid) begin
        if (expired) begin
          state     <= S_IDLE;
          frame_err <= 1'b1;
        end
      end else begin
        case (state)
          S_ADDR: begin
            if (pend_type == CMD_REG_WR) begin
              addr_q <= rx_data[ADDR_WIDTH-1:0];
              state  <= S_WDATA;
            end else begin
              cmd_addr  <= rx_data[ADDR_WIDTH-1:0];
              cmd_type  <= CMD_REG_RD;
              cmd_valid <= 1'b1;
              state     <= S_HOLD;
            end
          end
          S_WDATA: begin
            cmd_addr  <= addr_q;
            cmd_data  <= rx_data;
            cmd_type  <= CMD_REG_WR;
            cmd_valid <= 1'b1;
            state     <= S_HOLD;
          end
          S_OPA: begin
            opa_q <= rx_data;
            state <= S_OPB;
          end
          S_OPB: begin
            opb_q <= rx_data;
            state <= S_FUN;
          end
          S_FUN: begin
            if (pend_type == CMD_ALU_OP) begin
              cmd_data <= opa_q;
              cmd_opb  <= opb_q;
            end
            cmd_fun   <= rx_data[3:0];
            cmd_type  <= pend_type;
            cmd_valid <= 1'b1;
            state     <= S_HOLD;
          end
          S_HOLD: begin
            if (rx_valid && !cmd_ready) begin
              overrun <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: directed scenarios plus random
// frames checked against a frame-level reference model.
module tb_cmd_frame_parser;
  import cmd_defs_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 1024;
  localparam int EW = 2 + AW + DW + DW + 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [1:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] cmd_opb;
  logic [3:0]    cmd_fun;
  logic          frame_err;
  logic          overrun;
  logic [2:0]    fsm_state;
  logic [EW-1:0] got;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    frm[$];
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_opb = '0;
  logic [3:0]    m_fun = '0;

  assign got = {cmd_type, cmd_addr, cmd_data, cmd_opb, cmd_fun};

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  cmd_frame_parser #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_type (cmd_type),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_opb  (cmd_opb),
    .cmd_fun  (cmd_fun),
    .frame_err(frame_err),
    .overrun  (overrun),
    .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  // A completed frame updates only the fields its type carries; the command
  // is the frame type plus the full set of held field values.
  task automatic model_frame();
    logic [1:0] t;
    t = 2'b00;
    case (frm[0])
      8'hAA: begin t = 2'b00; m_addr = frm[1][AW-1:0]; m_data = frm[2]; end
      8'hBB: begin t = 2'b01; m_addr = frm[1][AW-1:0]; end
      8'hCC: begin t = 2'b10; m_data = frm[1]; m_opb = frm[2]; m_fun = frm[3][3:0]; end
      default: begin t = 2'b11; m_fun = frm[1][3:0]; end
    endcase
    exp_q.push_back({t, m_addr, m_data, m_opb, m_fun});
  endtask

  task automatic model_reset();
    m_addr = '0; m_data = '0; m_opb = '0; m_fun = '0;
  endtask

  // ---------------- driver tasks ----------------
  // All driver tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_frm(input int max_gap);
    for (int i = 0; i < frm.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) @(negedge CLK);
      send_byte(frm[i]);
    end
  endtask

  task automatic build_frame(input int t);
    frm = {};
    case (t)
      0: begin frm.push_back(8'hAA); frm.push_back(8'($urandom_range(0, 255)));
               frm.push_back(8'($urandom_range(0, 255))); end
      1: begin frm.push_back(8'hBB); frm.push_back(8'($urandom_range(0, 255))); end
      2: begin frm.push_back(8'hCC); frm.push_back(8'($urandom_range(0, 255)));
               frm.push_back(8'($urandom_range(0, 255)));
               frm.push_back(8'($urandom_range(0, 255))); end
      default: begin frm.push_back(8'hDD); frm.push_back(8'($urandom_range(0, 255))); end
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({cmd_valid, got, frame_err, overrun} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {cmd_valid, got, frame_err, overrun});
    end
    RST = 1'b0; rx_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (fsm_state !== S_IDLE || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ignore_rx: got state %0d valid %b required state 0 valid 0",
               fsm_state, cmd_valid);
    end
  endtask

  task automatic test_reg_write();
    logic [EW-1:0] e;
    cmd_ready = 1'b1;
    frm = {8'hAA, 8'h05, 8'h3C};
    model_frame();
    send_byte(8'hAA);
    send_byte(8'h05);
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL wr_early_valid: got %b required 0", cmd_valid);
    end
    send_byte(8'h3C);
    e = exp_q.pop_front();
    n_cmp++;
    if (cmd_valid !== 1'b1 || got !== e) begin
      n_err++; $display("FAIL wr_cmd: got valid %b fields %h required valid 1 fields %h",
                        cmd_valid, got, e);
    end
    @(negedge CLK);
    n_cmp++;
    if (cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL wr_retire: got valid %b required 0", cmd_valid);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_alu_hold();
    logic [EW-1:0] e;
    int bad;
    cmd_ready = 1'b0;
    frm = {8'hCC, 8'h12, 8'h34, 8'h08};
    model_frame();
    send_frm(0);
    e = exp_q.pop_front();
    n_cmp++;
    if (cmd_valid !== 1'b1 || got !== e) begin
      n_err++; $display("FAIL alu_cmd: got valid %b fields %h required valid 1 fields %h",
                        cmd_valid, got, e);
    end
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (cmd_valid !== 1'b1 || got !== e) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL alu_hold_stable: got %0d unstable cycles required 0", bad);
    end
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
    n_cmp++;
    if (cmd_valid !== 1'b0 || fsm_state !== S_IDLE) begin
      n_err++; $display("FAIL alu_handshake: got valid %b state %0d required valid 0 state 0",
                        cmd_valid, fsm_state);
    end
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h7E);
    n_cmp++;
    if (frame_err !== 1'b1 || fsm_state !== S_IDLE || cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL bad_opcode: got err %b state %0d valid %b required err 1 state 0 valid 0",
                        frame_err, fsm_state, cmd_valid);
    end
    @(negedge CLK);
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_err++; $display("FAIL bad_opcode_pulse: got err %b required 0", frame_err);
    end
  endtask

  task automatic test_timeout();
    logic [EW-1:0] e;
    cmd_ready = 1'b0;
    send_byte(8'hBB);
    repeat (TO - 1) @(negedge CLK);
    n_cmp++;
    if (frame_err !== 1'b0 || fsm_state !== S_ADDR) begin
      n_err++; $display("FAIL timeout_early: got err %b state %0d required err 0 state 1",
                        frame_err, fsm_state);
    end
    @(negedge CLK);
    n_cmp++;
    if (frame_err !== 1'b1 || fsm_state !== S_IDLE || cmd_valid !== 1'b0) begin
      n_err++; $display("FAIL timeout_err: got err %b state %0d valid %b required err 1 state 0 valid 0",
                        frame_err, fsm_state, cmd_valid);
    end
    @(negedge CLK);
    frm = {8'hDD, 8'h03};
    model_frame();
    send_frm(0);
    e = exp_q.pop_front();
    n_cmp++;
    if (cmd_valid !== 1'b1 || got !== e) begin
      n_err++; $display("FAIL timeout_next_nop: got valid %b fields %h required valid 1 fields %h",
                        cmd_valid, got, e);
    end
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
  endtask

  task automatic test_timeout_race();
    logic [EW-1:0] e;
    cmd_ready = 1'b0;
    frm = {8'hBB, 8'h09};
    model_frame();
    send_byte(8'hBB);
    repeat (TO - 1) @(negedge CLK);
    send_byte(8'h09);
    e = exp_q.pop_front();
    n_cmp++;
    if (cmd_valid !== 1'b1 || frame_err !== 1'b0 || got !== e) begin
      n_err++; $display("FAIL timeout_race: got valid %b err %b fields %h required valid 1 err 0 fields %h",
                        cmd_valid, frame_err, got, e);
    end
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [EW-1:0] e;
    cmd_ready = 1'b0;
    frm = {8'hDD, 8'h01};
    model_frame();
    send_frm(0);
    e = exp_q.pop_front();
    send_byte(8'hAA);
    n_cmp++;
    if (overrun !== 1'b1 || cmd_valid !== 1'b1 || got !== e || fsm_state !== S_HOLD) begin
      n_err++; $display("FAIL overrun_drop: got ovr %b valid %b fields %h state %0d required ovr 1 valid 1 fields %h state 6",
                        overrun, cmd_valid, got, fsm_state, e);
    end
    @(negedge CLK);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++; $display("FAIL overrun_pulse: got %b required 0", overrun);
    end
    cmd_ready = 1'b1;
    send_byte(8'hAA);
    cmd_ready = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0 || cmd_valid !== 1'b0 || fsm_state !== S_ADDR) begin
      n_err++; $display("FAIL retire_and_start: got ovr %b valid %b state %0d required ovr 0 valid 0 state 1",
                        overrun, cmd_valid, fsm_state);
    end
    frm = {8'hAA, 8'h07, 8'h99};
    model_frame();
    send_byte(8'h07);
    send_byte(8'h99);
    e = exp_q.pop_front();
    n_cmp++;
    if (cmd_valid !== 1'b1 || got !== e) begin
      n_err++; $display("FAIL b2b_write: got valid %b fields %h required valid 1 fields %h",
                        cmd_valid, got, e);
    end
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] e;
    cmd_ready = 1'b0;
    send_byte(8'hCC);
    send_byte(8'h12);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    n_cmp++;
    if ({cmd_valid, got, frame_err, overrun} !== '0 || fsm_state !== S_IDLE) begin
      n_err++; $display("FAIL mid_reset: got %h state %0d required 0 state 0",
                        {cmd_valid, got, frame_err, overrun}, fsm_state);
    end
    frm = {8'hAA, 8'h02, 8'h55};
    model_frame();
    send_frm(0);
    e = exp_q.pop_front();
    n_cmp++;
    if (cmd_valid !== 1'b1 || got !== e || frame_err !== 1'b0) begin
      n_err++; $display("FAIL post_reset_write: got valid %b fields %h err %b required valid 1 fields %h err 0",
                        cmd_valid, got, frame_err, e);
    end
    cmd_ready = 1'b1;
    @(negedge CLK);
    cmd_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [EW-1:0] e;
    logic [7:0]    b;
    logic          pending;
    pending = 1'b0;
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      if ($urandom_range(0, 5) == 0) begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
        cmd_ready = pending;
        send_byte(b);
        cmd_ready = 1'b0;
        pending = 1'b0;
        n_cmp++;
        if (frame_err !== 1'b1 || cmd_valid !== 1'b0) begin
          n_err++; $display("FAIL rand_bad_opcode %h: got err %b valid %b required err 1 valid 0",
                            b, frame_err, cmd_valid);
        end
      end else begin
        build_frame($urandom_range(0, 3));
        model_frame();
        // A held command retires on the same edge as the next opcode byte.
        cmd_ready = pending;
        send_byte(frm[0]);
        cmd_ready = 1'b0;
        for (int i = 1; i < frm.size(); i++) begin
          repeat ($urandom_range(0, 4)) @(negedge CLK);
          send_byte(frm[i]);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cmd_valid !== 1'b1 || got !== e) begin
          n_err++; $display("FAIL rand_cmd it%0d: got valid %b fields %h required valid 1 fields %h",
                            it, cmd_valid, got, e);
        end
        pending = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          cmd_ready = 1'b1;
          @(negedge CLK);
          cmd_ready = 1'b0;
          pending = 1'b0;
          n_cmp++;
          if (cmd_valid !== 1'b0) begin
            n_err++; $display("FAIL rand_retire it%0d: got valid %b required 0", it, cmd_valid);
          end
        end
      end
    end
    if (pending) begin
      cmd_ready = 1'b1;
      @(negedge CLK);
      cmd_ready = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_queue_drained: got %0d left required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reg_write();
    test_alu_hold();
    test_bad_opcode();
    test_timeout();
    test_timeout_race();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
